// File: rtl/patbuf_load_arbiter_if.sv
// rtl/patbuf_load_arbiter_if.sv - PAT, host-burst and pattern-buffer signals of the load arbiter
interface patbuf_load_arbiter_if #(
  parameter int d_width      = 8,
  parameter int bufp_width   = 3,
  parameter int fieldp_width = 5,
  parameter int len_width    = 6
);
  localparam int aw = bufp_width + fieldp_width;

  logic [aw-1:0]        pat_fieldwp;
  logic                 pat_we_low;
  logic                 pat_we_high;
  logic [d_width-1:0]   pat_wdata;

  logic                 host_start;
  logic [aw-1:0]        host_base;
  logic [len_width-1:0] host_len;
  logic                 host_high;
  logic                 host_valid;
  logic [d_width-1:0]   host_data;
  logic                 host_ready;
  logic                 host_busy;
  logic                 host_done;

  logic [aw-1:0]        buf_fieldwp;
  logic                 field_write_en_low;
  logic                 field_write_en_high;
  logic [d_width-1:0]   field_wdata;

  modport master (
    output pat_fieldwp, pat_we_low, pat_we_high, pat_wdata,
    output host_start, host_base, host_len, host_high, host_valid, host_data,
    input  host_ready, host_busy, host_done,
    input  buf_fieldwp, field_write_en_low, field_write_en_high, field_wdata
  );

  modport slave (
    input  pat_fieldwp, pat_we_low, pat_we_high, pat_wdata,
    input  host_start, host_base, host_len, host_high, host_valid, host_data,
    output host_ready, host_busy, host_done,
    output buf_fieldwp, field_write_en_low, field_write_en_high, field_wdata
  );
endinterface

// File: rtl/patbuf_load_arbiter.sv
// rtl/patbuf_load_arbiter.sv - shares the pattern-buffer write port between PAT and a host burst loader
module patbuf_load_arbiter #(
  parameter int d_width      = 8,
  parameter int bufp_width   = 3,
  parameter int fieldp_width = 5,
  parameter int len_width    = 6
) (
  input logic                  clk,
  input logic                  reset,
  patbuf_load_arbiter_if.slave bus
);
  localparam int aw = bufp_width + fieldp_width;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  state_e               state_q, state_d;
  logic [aw-1:0]        base_q, base_d;
  logic [len_width-1:0] len_q, len_d;
  logic [len_width-1:0] count_q, count_d;
  logic                 high_q, high_d;

  logic [aw-1:0]        buf_fieldwp_q;
  logic                 en_low_q, en_high_q;
  logic [d_width-1:0]   wdata_q;

  logic                 pat_any;
  logic                 last_beat;
  logic [aw-1:0]        host_addr;
  logic                 ready;
  logic                 busy;
  logic                 done;
  logic                 accept;

  assign pat_any   = bus.pat_we_low | bus.pat_we_high;
  // len_q == 0 wraps to all-ones here, giving the full 2^len_width beats
  assign last_beat = (count_q == len_q - len_width'(1));
  assign host_addr = base_q + aw'(count_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      high_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      count_q <= count_d;
      high_q  <= high_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    count_d = count_q;
    high_d  = high_q;
    case (state_q)
      IDLE: begin
        if (bus.host_start) begin
          base_d  = bus.host_base;
          len_d   = bus.host_len;
          high_d  = bus.host_high;
          count_d = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          count_d = count_q + len_width'(1);
          if (last_beat) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is combinational so a PAT strobe stalls the host in the same cycle
  always_comb begin
    ready  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state_q)
      LOAD: begin
        ready = !pat_any;
        busy  = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
    accept = ready & bus.host_valid;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_fieldwp_q <= '0;
      en_low_q      <= 1'b0;
      en_high_q     <= 1'b0;
      wdata_q       <= '0;
    end else if (pat_any) begin
      buf_fieldwp_q <= bus.pat_fieldwp;
      en_low_q      <= bus.pat_we_low;
      en_high_q     <= bus.pat_we_high;
      wdata_q       <= bus.pat_wdata;
    end else if (accept) begin
      buf_fieldwp_q <= host_addr;
      en_low_q      <= !high_q;
      en_high_q     <= high_q;
      wdata_q       <= bus.host_data;
    end else begin
      en_low_q      <= 1'b0;
      en_high_q     <= 1'b0;
    end
  end

  assign bus.host_ready          = ready;
  assign bus.host_busy           = busy;
  assign bus.host_done           = done;
  assign bus.buf_fieldwp         = buf_fieldwp_q;
  assign bus.field_write_en_low  = en_low_q;
  assign bus.field_write_en_high = en_high_q;
  assign bus.field_wdata         = wdata_q;
endmodule

// File: tb/tb_patbuf_load_arbiter.sv
// tb/tb_patbuf_load_arbiter.sv - self-checking bench for patbuf_load_arbiter
module tb_patbuf_load_arbiter;
  localparam int DW = 8, BW = 3, FW = 5, LW = 6;

  logic clk = 1'b0;
  logic reset = 1'b0;

  patbuf_load_arbiter_if #(.d_width(DW), .bufp_width(BW), .fieldp_width(FW), .len_width(LW)) bus ();

  patbuf_load_arbiter #(.d_width(DW), .bufp_width(BW), .fieldp_width(FW), .len_width(LW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int n_done = 0, n_wlo = 0, n_whi = 0;

  // Reference model: burst described by base, total beats and beats done so far
  int m_phase, m_base, m_total, m_idx, m_high;
  int e_addr, e_lo, e_hi, e_data, e_busy, e_done;

  typedef struct {
    logic       start;
    logic [7:0] base;
    logic [5:0] len;
    logic       high;
    logic       valid;
    logic [7:0] data;
    logic       plo;
    logic       phi;
    logic [7:0] paddr;
    logic [7:0] pdata;
    logic       x_ready;
    logic       x_lo;
    logic       x_hi;
    logic [7:0] x_addr;
    logic [7:0] x_data;
    logic       x_busy;
    logic       x_done;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int model_ready();
    return (m_phase == 1 && !(bus.pat_we_low || bus.pat_we_high)) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_base = 0; m_total = 0; m_idx = 0; m_high = 0;
    e_addr = 0; e_lo = 0; e_hi = 0; e_data = 0; e_busy = 0; e_done = 0;
  endtask

  task automatic model_update();
    int acc;
    acc = model_ready() & int'(bus.host_valid);
    if (bus.pat_we_low || bus.pat_we_high) begin
      e_addr = int'(bus.pat_fieldwp);
      e_data = int'(bus.pat_wdata);
      e_lo   = int'(bus.pat_we_low);
      e_hi   = int'(bus.pat_we_high);
    end else if (acc != 0) begin
      e_addr = (m_base + m_idx) % 256;
      e_data = int'(bus.host_data);
      e_lo   = 1 - m_high;
      e_hi   = m_high;
    end else begin
      e_lo = 0;
      e_hi = 0;
    end
    case (m_phase)
      0: if (bus.host_start) begin
        m_base  = int'(bus.host_base);
        m_total = (bus.host_len == 0) ? 64 : int'(bus.host_len);
        m_high  = int'(bus.host_high);
        m_idx   = 0;
        m_phase = 1;
      end
      1: if (acc != 0) begin
        m_idx++;
        if (m_idx == m_total) m_phase = 2;
      end
      default: m_phase = 0;
    endcase
    e_busy = (m_phase != 0) ? 1 : 0;
    e_done = (m_phase == 2) ? 1 : 0;
  endtask

  task automatic idle_inputs();
    bus.pat_fieldwp = '0; bus.pat_we_low = 1'b0; bus.pat_we_high = 1'b0; bus.pat_wdata = '0;
    bus.host_start = 1'b0; bus.host_base = '0; bus.host_len = '0; bus.host_high = 1'b0;
    bus.host_valid = 1'b0; bus.host_data = '0;
  endtask

  task automatic set_start(input logic [7:0] base, input logic [5:0] len, input logic high);
    bus.host_start = 1'b1; bus.host_base = base; bus.host_len = len; bus.host_high = high;
  endtask

  // One clock: ready checked at negedge, registered outputs 1 time unit after posedge
  task automatic step(input int x_ready);
    @(negedge clk);
    chk("host_ready", 32'(bus.host_ready), 32'(model_ready()));
    if (x_ready >= 0) chk("tab_ready", 32'(bus.host_ready), 32'(x_ready));
    @(posedge clk);
    model_update();
    #1;
    chk("en_low", 32'(bus.field_write_en_low), 32'(e_lo));
    chk("en_high", 32'(bus.field_write_en_high), 32'(e_hi));
    chk("fieldwp", 32'(bus.buf_fieldwp), 32'(e_addr));
    chk("wdata", 32'(bus.field_wdata), 32'(e_data));
    chk("busy", 32'(bus.host_busy), 32'(e_busy));
    chk("done", 32'(bus.host_done), 32'(e_done));
    n_done += int'(bus.host_done);
    n_wlo  += int'(bus.field_write_en_low);
    n_whi  += int'(bus.field_write_en_high);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_ready"}, 32'(bus.host_ready), 0);
    chk({nm, "_busy"}, 32'(bus.host_busy), 0);
    chk({nm, "_done"}, 32'(bus.host_done), 0);
    chk({nm, "_en"}, 32'({bus.field_write_en_low, bus.field_write_en_high}), 0);
    chk({nm, "_fieldwp"}, 32'(bus.buf_fieldwp), 0);
    chk({nm, "_wdata"}, 32'(bus.field_wdata), 0);
  endtask

  // Entered just after a posedge; asserts reset between edges
  task automatic do_reset(input string nm);
    reset = 1'b0;
    #2;
    check_reset_outputs(nm);
    model_reset();
    idle_inputs();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int d0, lo0, hi0;
    idle_inputs();
    model_reset();

    vt[0] = '{1'b0, 8'h00, 6'd0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 8'h5C, 1'b0, 1'b1, 1'b1, 8'h33, 8'h5C, 1'b0, 1'b0};
    vt[1] = '{1'b1, 8'h10, 6'd4, 1'b0, 1'b1, 8'hA0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h33, 8'h5C, 1'b1, 1'b0};
    vt[2] = '{1'b0, 8'h00, 6'd0, 1'b0, 1'b1, 8'hA0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h10, 8'hA0, 1'b1, 1'b0};
    vt[3] = '{1'b0, 8'h00, 6'd0, 1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h11, 8'hA1, 1'b1, 1'b0};
    vt[4] = '{1'b0, 8'h00, 6'd0, 1'b0, 1'b1, 8'hA2, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h12, 8'hA2, 1'b1, 1'b0};
    vt[5] = '{1'b0, 8'h00, 6'd0, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h13, 8'hA3, 1'b1, 1'b1};
    vt[6] = '{1'b0, 8'h00, 6'd0, 1'b0, 1'b1, 8'hA4, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h13, 8'hA3, 1'b0, 1'b0};
    vt[7] = '{1'b0, 8'h00, 6'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h13, 8'hA3, 1'b0, 1'b0};

    #1;
    check_reset_outputs("rst0");
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      bus.host_start = vt[i].start; bus.host_base = vt[i].base; bus.host_len = vt[i].len;
      bus.host_high = vt[i].high; bus.host_valid = vt[i].valid; bus.host_data = vt[i].data;
      bus.pat_we_low = vt[i].plo; bus.pat_we_high = vt[i].phi;
      bus.pat_fieldwp = vt[i].paddr; bus.pat_wdata = vt[i].pdata;
      step(int'(vt[i].x_ready));
      chk($sformatf("tab%0d_lo", i), 32'(bus.field_write_en_low), 32'(vt[i].x_lo));
      chk($sformatf("tab%0d_hi", i), 32'(bus.field_write_en_high), 32'(vt[i].x_hi));
      chk($sformatf("tab%0d_addr", i), 32'(bus.buf_fieldwp), 32'(vt[i].x_addr));
      chk($sformatf("tab%0d_data", i), 32'(bus.field_wdata), 32'(vt[i].x_data));
      chk($sformatf("tab%0d_busy", i), 32'(bus.host_busy), 32'(vt[i].x_busy));
      chk($sformatf("tab%0d_done", i), 32'(bus.host_done), 32'(vt[i].x_done));
    end
    idle_inputs();

    // PAT collision in the middle of a burst
    lo0 = n_wlo; d0 = n_done;
    set_start(8'h20, 6'd3, 1'b0);
    step(0);
    idle_inputs();
    bus.host_valid = 1'b1; bus.host_data = 8'hB0;
    bus.pat_we_high = 1'b1; bus.pat_fieldwp = 8'h05; bus.pat_wdata = 8'hAA;
    step(0);
    chk("coll_pat_hi", 32'(bus.field_write_en_high), 1);
    chk("coll_pat_addr", 32'(bus.buf_fieldwp), 32'h05);
    chk("coll_pat_data", 32'(bus.field_wdata), 32'hAA);
    bus.pat_we_high = 1'b0;
    step(1);
    chk("coll_beat0_addr", 32'(bus.buf_fieldwp), 32'h20);
    chk("coll_beat0_data", 32'(bus.field_wdata), 32'hB0);
    bus.host_data = 8'hB1; step(1);
    bus.host_data = 8'hB2; step(1);
    bus.host_valid = 1'b0;
    step(0);
    chk("coll_writes", 32'(n_wlo - lo0), 3);
    chk("coll_dones", 32'(n_done - d0), 1);

    // Address wrap with a full 64-beat burst
    hi0 = n_whi; d0 = n_done;
    set_start(8'hFE, 6'd0, 1'b1);
    step(0);
    idle_inputs();
    bus.host_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      bus.host_data = 8'(i);
      step(-1);
    end
    chk("wrap_last_addr", 32'(bus.buf_fieldwp), 32'h3D);
    chk("wrap_done", 32'(bus.host_done), 1);
    bus.host_valid = 1'b0;
    step(0);
    chk("wrap_writes", 32'(n_whi - hi0), 64);
    chk("wrap_dones", 32'(n_done - d0), 1);

    // Host gaps, with start pulses ignored during LOAD
    lo0 = n_wlo; d0 = n_done;
    set_start(8'h80, 6'd2, 1'b0);
    bus.host_valid = 1'b1;
    step(0);
    for (int i = 0; i < 4; i++) begin
      bus.host_valid = (i == 0 || i == 3);
      bus.host_data = 8'(8'hC0 + i);
      set_start(8'h07, 6'd5, 1'b1);
      step(-1);
      chk($sformatf("gap%0d_lo", i), 32'(bus.field_write_en_low), (i == 0 || i == 3) ? 1 : 0);
    end
    idle_inputs();
    step(0);
    step(0);
    chk("gap_writes", 32'(n_wlo - lo0), 2);
    chk("gap_dones", 32'(n_done - d0), 1);
    chk("gap_busy_after", 32'(bus.host_busy), 0);

    // Reset mid-burst, then a fresh single-beat burst
    d0 = n_done;
    set_start(8'h50, 6'd5, 1'b0);
    step(0);
    idle_inputs();
    bus.host_valid = 1'b1;
    step(1);
    step(1);
    do_reset("rstmid");
    step(0);
    chk("rstmid_no_done", 32'(n_done - d0), 0);
    set_start(8'h40, 6'd1, 1'b0);
    step(0);
    idle_inputs();
    bus.host_valid = 1'b1; bus.host_data = 8'h9E;
    step(1);
    chk("post_rst_addr", 32'(bus.buf_fieldwp), 32'h40);
    chk("post_rst_done", 32'(bus.host_done), 1);
    idle_inputs();
    step(0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bus.pat_we_low  = ($urandom_range(0, 99) < 15);
      bus.pat_we_high = ($urandom_range(0, 99) < 15);
      bus.pat_fieldwp = 8'($urandom);
      bus.pat_wdata   = 8'($urandom);
      bus.host_start  = ($urandom_range(0, 99) < 10);
      bus.host_base   = 8'($urandom);
      bus.host_len    = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(1, 7));
      bus.host_high   = 1'($urandom);
      bus.host_valid  = ($urandom_range(0, 99) < 65);
      bus.host_data   = 8'($urandom);
      if ($urandom_range(0, 999) < 3) do_reset("rst_rand");
      else step(-1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
